// File: rtl/ahb_master_arbiter.sv
// Round-robin arbiter that shares one AHB-Lite bus among NUM_MASTERS masters.
// Ownership changes only on an IDLE, unlocked address phase that the bus accepts.
module ahb_master_arbiter #(
  parameter int NUM_MASTERS = 2,
  localparam int MW = $clog2(NUM_MASTERS)
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [NUM_MASTERS*32-1:0] M_HADDR,
  input  logic [NUM_MASTERS*2-1:0]  M_HTRANS,
  input  logic [NUM_MASTERS-1:0]    M_HWRITE,
  input  logic [NUM_MASTERS*3-1:0]  M_HSIZE,
  input  logic [NUM_MASTERS*3-1:0]  M_HBURST,
  input  logic [NUM_MASTERS-1:0]    M_HMASTLOCK,
  input  logic [NUM_MASTERS*32-1:0] M_HWDATA,
  output logic [NUM_MASTERS-1:0]    M_HREADY,
  output logic [31:0]               M_HRDATA,
  output logic [31:0]               HADDR,
  output logic [1:0]                HTRANS,
  output logic                      HWRITE,
  output logic [2:0]                HSIZE,
  output logic [2:0]                HBURST,
  output logic                      HMASTLOCK,
  output logic [31:0]               HWDATA,
  input  logic                      HREADY,
  input  logic [31:0]               HRDATA,
  output logic [MW-1:0]             HMASTER
);

  logic [MW-1:0] addr_owner_q, addr_owner_d;
  logic [MW-1:0] data_owner_q, data_owner_d;
  logic [MW-1:0] cand;

  logic [31:0] haddr_a     [NUM_MASTERS];
  logic [1:0]  htrans_a    [NUM_MASTERS];
  logic        hwrite_a    [NUM_MASTERS];
  logic [2:0]  hsize_a     [NUM_MASTERS];
  logic [2:0]  hburst_a    [NUM_MASTERS];
  logic        hmastlock_a [NUM_MASTERS];
  logic [31:0] hwdata_a    [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] req;
  logic        handover;

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
    assign haddr_a[gi]     = M_HADDR[gi*32 +: 32];
    assign htrans_a[gi]    = M_HTRANS[gi*2 +: 2];
    assign hwrite_a[gi]    = M_HWRITE[gi];
    assign hsize_a[gi]     = M_HSIZE[gi*3 +: 3];
    assign hburst_a[gi]    = M_HBURST[gi*3 +: 3];
    assign hmastlock_a[gi] = M_HMASTLOCK[gi];
    assign hwdata_a[gi]    = M_HWDATA[gi*32 +: 32];
    // Non-owners see a permanent wait state and must hold their address.
    assign M_HREADY[gi]    = (addr_owner_q == MW'(gi)) ? HREADY : 1'b0;
    assign req[gi]         = htrans_a[gi][1] && (addr_owner_q != MW'(gi));
  end

  assign HADDR     = haddr_a[addr_owner_q];
  assign HTRANS    = htrans_a[addr_owner_q];
  assign HWRITE    = hwrite_a[addr_owner_q];
  assign HSIZE     = hsize_a[addr_owner_q];
  assign HBURST    = hburst_a[addr_owner_q];
  assign HMASTLOCK = hmastlock_a[addr_owner_q];
  assign HWDATA    = hwdata_a[data_owner_q];
  assign M_HRDATA  = HRDATA;
  assign HMASTER   = addr_owner_q;

  assign handover = HREADY && (htrans_a[addr_owner_q] == 2'b00) &&
                    !hmastlock_a[addr_owner_q] && (|req);

  // Scan downwards so the nearest requester after the current owner wins.
  always_comb begin
    addr_owner_d = addr_owner_q;
    cand         = addr_owner_q;
    if (handover) begin
      for (int k = NUM_MASTERS - 1; k >= 1; k--) begin
        cand = MW'((int'(addr_owner_q) + k) % NUM_MASTERS);
        if (req[cand]) addr_owner_d = cand;
      end
    end
  end

  assign data_owner_d = HREADY ? addr_owner_q : data_owner_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_owner_q <= '0;
      data_owner_q <= '0;
    end else begin
      addr_owner_q <= addr_owner_d;
      data_owner_q <= data_owner_d;
    end
  end

endmodule
